// File: rtl/mem_port_arbiter4.sv
// ============================================================================
//  Module   : mem_port_arbiter4
//  Purpose  : Round-robin owner arbiter for a shared 4:1 memory port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter4 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam int            CW       = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    gnt_q;
  logic [1:0]    sel_q;
  logic          busy_q;
  logic          timeout_q;

  logic [1:0]    base_ptr_d;
  logic [1:0]    win_idx_d;
  logic          win_vld_d;
  logic          forced_d;
  logic          release_d;

  // A releasing owner hands priority to its neighbour, so it ranks last.
  always_comb begin
    base_ptr_d = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
    win_vld_d  = 1'b0;
    win_idx_d  = '0;
    for (int k = 3; k >= 0; k--) begin
      if (req[base_ptr_d + 2'(k)]) begin
        win_vld_d = 1'b1;
        win_idx_d = base_ptr_d + 2'(k);
      end
    end
    forced_d  = (HOLD_MAX != 0) && (state_q == GRANT) && (cnt_q == CNT_LAST) && !done;
    release_d = (state_q == GRANT) && (done || forced_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (win_vld_d) begin
            state_q <= GRANT;
            gnt_q   <= 4'b0001 << win_idx_d;
            sel_q   <= win_idx_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (release_d) begin
            ptr_q     <= base_ptr_d;
            timeout_q <= forced_d;
            cnt_q     <= '0;
            if (win_vld_d) begin
              gnt_q <= 4'b0001 << win_idx_d;
              sel_q <= win_idx_d;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            timeout_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter4.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter4
//  Purpose  : Directed self-checking bench for mem_port_arbiter4 (HOLD_MAX=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  mem_port_arbiter4 #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector is {gnt, sel, busy, timeout}.
  task automatic chk(input string tag, input logic [7:0] expv);
    logic [7:0] obs;
    obs = {gnt, sel, busy, timeout};
    chk_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s: observed gnt/sel/busy/to=%b expected %b", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    do_reset();
    chk("reset_state", 8'b0000_00_0_0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_no_req", 8'b0000_00_0_0);
    end

    // Two requesters, handoff without a bubble
    do_reset();
    req = 4'b1010;
    tick();
    chk("rr2_first", 8'b0010_01_1_0);
    done = 1'b1;
    tick();
    chk("rr2_handoff", 8'b1000_11_1_0);
    tick();
    chk("rr2_wrap", 8'b0010_01_1_0);
    done = 1'b0;
    tick();
    chk("rr2_hold", 8'b0010_01_1_0);

    // Full rotation
    do_reset();
    req = 4'b1111;
    tick();
    chk("rr4_0", 8'b0001_00_1_0);
    done = 1'b1;
    tick();
    chk("rr4_1", 8'b0010_01_1_0);
    tick();
    chk("rr4_2", 8'b0100_10_1_0);
    tick();
    chk("rr4_3", 8'b1000_11_1_0);
    tick();
    chk("rr4_4", 8'b0001_00_1_0);
    done = 1'b0;

    // Forced release of a sole requester, then re-grant
    do_reset();
    req = 4'b0100;
    tick();
    chk("hold_c1", 8'b0100_10_1_0);
    tick();
    chk("hold_c2", 8'b0100_10_1_0);
    tick();
    chk("hold_c3", 8'b0100_10_1_0);
    tick();
    chk("hold_c4", 8'b0100_10_1_0);
    tick();
    chk("timeout_regrant", 8'b0100_10_1_1);
    req = 4'b0000;
    tick();
    chk("drop_req_c2", 8'b0100_10_1_0);
    tick();
    chk("drop_req_c3", 8'b0100_10_1_0);
    tick();
    chk("drop_req_c4", 8'b0100_10_1_0);
    tick();
    chk("timeout_to_idle", 8'b0000_10_0_1);
    tick();
    chk("idle_after_to", 8'b0000_10_0_0);

    // done coinciding with the limit is a normal release
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    tick();
    tick();
    chk("limit_c4", 8'b0100_10_1_0);
    done = 1'b1;
    req  = 4'b0000;
    tick();
    chk("done_at_limit", 8'b0000_10_0_0);
    done = 1'b1;
    tick();
    chk("done_ignored_idle", 8'b0000_10_0_0);
    done = 1'b0;

    // Reset mid-grant, then ptr restarts at 0
    do_reset();
    req = 4'b1000;
    tick();
    chk("own3", 8'b1000_11_1_0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("reset_mid_grant", 8'b0000_00_0_0);
    reset = 1'b0;
    req   = 4'b1001;
    tick();
    chk("post_reset_ptr0", 8'b0001_00_1_0);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule

`default_nettype wire
